// File: rtl/memory_bus_master_if.sv
// Request/response handshake and memory control signals of the memory bus master.
// The shared tristate data bus stays a plain inout port on the master itself.
interface memory_bus_master_if #(
    parameter int unsigned address_size = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [address_size-1:0] req_address;
    logic [15:0]             req_wdata;
    logic                    rsp_valid;
    logic                    rsp_write;
    logic [15:0]             rsp_data;
    logic                    mem_enable;
    logic                    mem_read_write;
    logic [address_size-1:0] mem_address;

    modport master (
        input  req_valid, req_write, req_address, req_wdata,
        output req_ready, rsp_valid, rsp_write, rsp_data,
        output mem_enable, mem_read_write, mem_address
    );

    modport slave (
        output req_valid, req_write, req_address, req_wdata,
        input  req_ready, rsp_valid, rsp_write, rsp_data,
        input  mem_enable, mem_read_write, mem_address
    );
endinterface

// File: rtl/memory_bus_master.sv
// Single-outstanding initiator for the shared 16-bit memory bus: IDLE -> WRITE/READ -> DONE.
// Every bus output is decoded from registered state only, so req_* never reaches mem_* combinationally.
module memory_bus_master #(
    parameter int unsigned address_size = 16
) (
    input  logic                clk,
    input  logic                reset,
    memory_bus_master_if.master bus,
    inout  wire  [15:0]         mem_data
);
    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e                  state_q, state_d;
    logic [address_size-1:0] addr_q;
    logic [15:0]             wdata_q;
    logic [15:0]             rdata_q;
    logic                    write_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.req_valid) begin
                addr_q  <= bus.req_address;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end
            // Memory read path is combinational, so data is settled at the closing edge.
            if (state_q == StRead) begin
                rdata_q <= mem_data;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        bus.req_ready      = 1'b0;
        bus.mem_enable     = 1'b0;
        bus.mem_read_write = 1'b1;
        bus.rsp_valid      = 1'b0;
        bus.rsp_write      = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = bus.req_write ? StWrite : StRead;
                end
            end
            StWrite: begin
                bus.mem_enable     = 1'b1;
                bus.mem_read_write = 1'b0;
                state_d            = StDone;
            end
            StRead: begin
                bus.mem_enable = 1'b1;
                state_d        = StDone;
            end
            StDone: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_write = write_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.mem_address = addr_q;
    assign bus.rsp_data    = rdata_q;

    // DONE doubles as the turnaround cycle: nothing drives the bus between a read and a write.
    assign mem_data = (state_q == StWrite) ? wdata_q : 16'hzzzz;
endmodule

// File: tb/tb_memory_bus_master.sv
// Self-checking bench for memory_bus_master: 8-bit-decoded memory, idle-bus probe driver,
// and a transaction-level reference model of memory contents and the held read word.
module tb_memory_bus_master;
    logic       clk;
    logic       reset;
    wire [15:0] mem_data;
    logic [15:0] probe_val;
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] ref_rsp;
    int tests_run;
    int tests_failed;

    memory_bus_master_if #(.address_size(16)) bus ();

    memory_bus_master #(.address_size(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on the closing edge of a write cycle.
    assign mem_data = (bus.mem_enable && bus.mem_read_write) ? mem[bus.mem_address[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (bus.mem_enable && !bus.mem_read_write) mem[bus.mem_address[7:0]] <= mem_data;
    end

    // Probe agent drives a random word whenever the bus is idle; any master drive corrupts it.
    assign mem_data = (!bus.mem_enable) ? probe_val : 16'hzzzz;
    always @(posedge clk) probe_val <= 16'($urandom);

    always @(negedge clk) begin
        if (bus.mem_enable === 1'b0) begin
            tests_run++;
            if (mem_data !== probe_val) begin
                tests_failed++;
                $display("FAIL bus_idle_owner: mem_data=%h required %h", mem_data, probe_val);
            end
        end
    end

    // One transaction: request at an IDLE negedge, bus cycle N+1, response N+2.
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input bit hold);
        logic [15:0] exp_bus;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_idle: req_ready=%b required 1", bus.req_ready);
        end
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_address = addr;
        bus.req_wdata   = wdata;
        @(negedge clk);
        bus.req_valid   = hold;
        bus.req_write   = 1'($urandom);
        bus.req_address = 16'($urandom);
        bus.req_wdata   = 16'($urandom);
        exp_bus = wr ? wdata : ref_mem[addr[7:0]];
        tests_run++;
        if (bus.mem_enable !== 1'b1 || bus.mem_read_write !== !wr || bus.req_ready !== 1'b0
            || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bus_cycle_ctrl: en=%b rw=%b rdy=%b rspv=%b required 1 %b 0 0",
                     bus.mem_enable, bus.mem_read_write, bus.req_ready, bus.rsp_valid, !wr);
        end
        tests_run++;
        if (bus.mem_address !== addr || mem_data !== exp_bus) begin
            tests_failed++;
            $display("FAIL bus_cycle_data: addr=%h data=%h required %h %h",
                     bus.mem_address, mem_data, addr, exp_bus);
        end
        tests_run++;
        if (bus.rsp_data !== ref_rsp) begin
            tests_failed++;
            $display("FAIL rsp_hold_busy: rsp_data=%h required %h", bus.rsp_data, ref_rsp);
        end
        if (wr) ref_mem[addr[7:0]] = wdata;
        else    ref_rsp = ref_mem[addr[7:0]];
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== wr || bus.rsp_data !== ref_rsp) begin
            tests_failed++;
            $display("FAIL response: valid=%b write=%b data=%h required 1 %b %h",
                     bus.rsp_valid, bus.rsp_write, bus.rsp_data, wr, ref_rsp);
        end
        tests_run++;
        if (bus.mem_enable !== 1'b0 || bus.mem_read_write !== 1'b1 || bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_ctrl: en=%b rw=%b rdy=%b required 0 1 0",
                     bus.mem_enable, bus.mem_read_write, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_write !== 1'b0
            || bus.rsp_data !== 16'h0000 || bus.mem_enable !== 1'b0
            || bus.mem_read_write !== 1'b1 || bus.mem_address !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_values: rdy=%b rspv=%b rspw=%b data=%h en=%b rw=%b addr=%h",
                     bus.req_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_data,
                     bus.mem_enable, bus.mem_read_write, bus.mem_address);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        ref_rsp = 16'h0000;
    endtask

    task automatic test_write_read();
        run_txn(1'b1, 16'h0012, 16'hBEEF, 1'b0);
        run_txn(1'b0, 16'h0012, 16'h0000, 1'b0);
    endtask

    task automatic test_address_forwarding();
        run_txn(1'b1, 16'hAB07, 16'h1234, 1'b0);
        run_txn(1'b0, 16'h0007, 16'h0000, 1'b0);
    endtask

    task automatic test_rsp_hold();
        run_txn(1'b1, 16'h0001, 16'h5A5A, 1'b0);
        run_txn(1'b0, 16'h0001, 16'h0000, 1'b0);
        run_txn(1'b1, 16'h0002, 16'($urandom), 1'b0);
        tests_run++;
        if (bus.rsp_data !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL rsp_hold_write: rsp_data=%h required 5a5a", bus.rsp_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) run_txn(1'b1, 16'(i), 16'($urandom), 1'b0);
        for (int i = 0; i < 200; i++) begin
            run_txn(1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            run_txn(!k[0], (k % 4 < 2) ? 16'h00FF : 16'h0100, 16'($urandom), 1'b1);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset_in_write();
        logic [15:0] old_val;
        old_val = ref_mem[8'h42];
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_address = 16'h0042;
        bus.req_wdata   = ~old_val;
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests_run++;
        if (bus.mem_enable !== 1'b1 || bus.mem_read_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_pre_write: en=%b rw=%b required 1 0",
                     bus.mem_enable, bus.mem_read_write);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_enable !== 1'b0 || bus.mem_read_write !== 1'b1 || bus.req_ready !== 1'b1
            || bus.rsp_valid !== 1'b0 || bus.mem_address !== 16'h0000
            || bus.rsp_data !== 16'h0000 || mem_data !== probe_val) begin
            tests_failed++;
            $display("FAIL rst_async: en=%b rw=%b rdy=%b rspv=%b addr=%h rsp=%h bus=%h probe=%h",
                     bus.mem_enable, bus.mem_read_write, bus.req_ready, bus.rsp_valid,
                     bus.mem_address, bus.rsp_data, mem_data, probe_val);
        end
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (bus.rsp_valid !== 1'b0 || bus.mem_enable !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_hold: rspv=%b en=%b required 0 0",
                         bus.rsp_valid, bus.mem_enable);
            end
        end
        @(posedge clk);
        #2 reset = 1'b1;
        ref_rsp = 16'h0000;
        run_txn(1'b0, 16'h0042, 16'h0000, 1'b0);
        tests_run++;
        if (bus.rsp_data !== old_val) begin
            tests_failed++;
            $display("FAIL rst_no_commit: rsp_data=%h required %h", bus.rsp_data, old_val);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        probe_val       = 16'h3C96;
        ref_rsp         = 16'h0000;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = 16'h0000;
        bus.req_wdata   = 16'h0000;
        test_reset();
        test_write_read();
        test_address_forwarding();
        test_rsp_hold();
        test_random();
        test_back_to_back();
        test_reset_in_write();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
